muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS execute stage. Owns the HI/LO registers.
- Decodes R-type funct for mult/multu/div/divu/mfhi/mflo/mthi/mtlo and runs a shift-add multiplier or a restoring divider over WIDTH cycles.
- Drives a stall to the pipeline while busy. Sits beside the ALU and its control; the ALU path is unaffected.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  R-type instruction in EX this cycle
- funct_i  input  6  instruction funct field
- rs_i  input  WIDTH  rs operand (multiplicand/dividend; mthi/mtlo source)
- rt_i  input  WIDTH  rt operand (multiplier/divisor)
- stall_o  output  1  combinational: valid_i & funct is a muldiv/move op & busy_o
- busy_o  output  1  registered: state != IDLE
- done_o  output  1  one-cycle pulse the cycle after HI/LO are written by mult/div
- mf_o  output  WIDTH  combinational: HI when funct=mfhi, LO when funct=mflo, else 0
- hi_o  output  WIDTH  HI register
- lo_o  output  WIDTH  LO register

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Reset (any time, including mid-iteration): state=IDLE, counter=0, HI=LO=0, busy_o=0, done_o=0, working registers=0. No partial result is ever committed.
- Funct codes: mult 6'h18, multu 6'h19, div 6'h1A, divu 6'h1B, mfhi 6'h10, mthi 6'h11, mflo 6'h12, mtlo 6'h13. Any other funct is ignored.
- States: IDLE, ITER, FIXUP.
- IDLE accepts an op when valid_i is high.
  - mthi/mtlo write HI/LO from rs_i at that edge. No busy.
  - mult/div: capture magnitudes (signed ops) or raw values (unsigned ops) and record result signs; counter=WIDTH; go to ITER.
  - div/divu with rt_i==0: go directly to FIXUP with HI<=rs_i, LO<=all-ones (busy for 1 cycle).
- ITER: one partial-product add or one trial subtraction per cycle; counter decrements; counter==1 -> FIXUP. Exactly WIDTH cycles.
- FIXUP:
  - Apply two's-complement negation:
    - product: negated if operand signs differ;
    - quotient: negated if signs differ;
    - remainder: takes the dividend's sign.
  - Write HI (product high / remainder) and LO (product low / quotient).
  - Go to IDLE; done_o is high in the following cycle.
- Latency: accept at edge E0 -> busy_o high for WIDTH+1 cycles -> HI/LO visible the cycle busy_o falls.
- Signed div MIN/-1: LO=MIN, HI=0 (falls out of the magnitude algorithm; no special case).
- Any muldiv/move op while busy: stall_o=1; request not accepted; upstream holds the instruction. mfhi/mflo stall until busy_o falls, then read the new values.
- Non-muldiv valid_i while busy: stall_o=0. Operation continues undisturbed.

Optional Feature:
- MULDIV_DIV0_FLAG_EN: adds output div0_o (1 bit, sticky).
  - Set at the FIXUP edge of a div/divu with divisor 0.
  - Cleared by reset or by the next accepted div/divu with a non-zero divisor.
- Without the macro: port absent; divide-by-zero results are unchanged.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct localparams FN_MULT..FN_MTLO;
  - state enum {IDLE, ITER, FIXUP};
  - function neg_if(value, cond).
- No sub-module: a single flat module. The datapath is too tightly coupled to the counter to split usefully.

Test Plan:
- mult rs=32'hFFFFFFFF, rt=2 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFE; busy_o high exactly 33 cycles; done_o single pulse.
- multu rs=32'hFFFFFFFF, rt=2 -> HI=32'h00000001, LO=32'hFFFFFFFE.
- div rs=-7, rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Then div 32'h80000000/-1 -> LO=32'h80000000, HI=0.
- divu rs=100, rt=0 -> HI=32'h64, LO=32'hFFFFFFFF, busy 1 cycle; with MULDIV_DIV0_FLAG_EN, div0_o=1 until the next divu 10/3 (LO=3, HI=1).
- mult in flight, then mflo held on valid_i -> stall_o=1 until busy_o falls; mf_o equals the new LO. An add funct during busy -> stall_o=0.
- rst_n asserted low at iteration 10 of a mult -> busy_o, HI, LO are 0 immediately (asynchronous). After release, mthi 32'h1234 -> hi_o=32'h1234 next cycle with no busy.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared funct codes, sequencer states and sign helper for the muldiv sequencer.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  // Wide enough for a full 2*WIDTH product; callers cast down to their width.
  function automatic logic [63:0] neg_if(input logic [63:0] value, input logic cond);
    return cond ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative mult/div sequencer owning HI/LO; optional sticky div0_o under MULDIV_DIV0_FLAG_EN.
// Busy WIDTH+1 cycles per mult/div (1 for divide-by-zero); stalls muldiv/move ops while busy.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] mf_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0_o
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  // acc_hi: product high / partial remainder; acc_lo: multiplier / dividend->quotient
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
  logic              div0_q, div0_d;
  logic              dz_q, dz_d;
`endif

  logic              md_op;
  logic              signed_op;
  logic [WIDTH-1:0]  rs_mag, rt_mag;
  logic [WIDTH:0]    msum;
  logic [WIDTH+1:0]  dtrial;

  always_comb begin
    md_op = funct_i inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  end

  assign busy_o  = (state_q != IDLE);
  assign stall_o = valid_i & md_op & busy_o;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
  assign div0_o  = div0_q;
`endif

  always_comb begin
    case (funct_i)
      FN_MFHI: mf_o = hi_q;
      FN_MFLO: mf_o = lo_q;
      default: mf_o = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
    div0_d    = div0_q;
    dz_d      = dz_q;
`endif
    signed_op = (funct_i == FN_MULT) || (funct_i == FN_DIV);
    rs_mag    = WIDTH'(neg_if(64'(rs_i), signed_op & rs_i[WIDTH-1]));
    rt_mag    = WIDTH'(neg_if(64'(rt_i), signed_op & rt_i[WIDTH-1]));
    msum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Extra top bit so the borrow is unambiguous when the shifted remainder overflows WIDTH.
    dtrial    = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opnd_q};

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          case (funct_i)
            FN_MTHI: hi_d = rs_i;
            FN_MTLO: lo_d = rs_i;
            FN_MULT, FN_MULTU: begin
              opnd_d   = rs_mag;
              acc_hi_d = '0;
              acc_lo_d = rt_mag;
              is_div_d = 1'b0;
              neg_lo_d = signed_op & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
              neg_hi_d = 1'b0;
              cnt_d    = CNT_W'(WIDTH);
              state_d  = ITER;
            end
            FN_DIV, FN_DIVU: begin
              is_div_d = 1'b1;
              if (rt_i == '0) begin
                opnd_d   = '0;
                acc_hi_d = rs_i;
                acc_lo_d = '1;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                cnt_d    = '0;
                state_d  = FIXUP;
`ifdef MULDIV_DIV0_FLAG_EN
                dz_d     = 1'b1;
`endif
              end else begin
                opnd_d   = rt_mag;
                acc_hi_d = '0;
                acc_lo_d = rs_mag;
                neg_lo_d = signed_op & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                neg_hi_d = signed_op & rs_i[WIDTH-1];
                cnt_d    = CNT_W'(WIDTH);
                state_d  = ITER;
`ifdef MULDIV_DIV0_FLAG_EN
                dz_d     = 1'b0;
                div0_d   = 1'b0;
`endif
              end
            end
            default: ;
          endcase
        end
      end

      ITER: begin
        if (is_div_q) begin
          if (!dtrial[WIDTH+1]) begin
            acc_hi_d = dtrial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = msum[WIDTH:1];
          acc_lo_d = {msum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      end

      FIXUP: begin
        if (is_div_q) begin
          hi_d = WIDTH'(neg_if(64'(acc_hi_q), neg_hi_q));
          lo_d = WIDTH'(neg_if(64'(acc_lo_q), neg_lo_q));
        end else begin
          {hi_d, lo_d} = (2*WIDTH)'(neg_if(64'({acc_hi_q, acc_lo_q}), neg_lo_q));
        end
`ifdef MULDIV_DIV0_FLAG_EN
        if (dz_q) div0_d = 1'b1;
        dz_d = 1'b0;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_q   <= div0_d;
      dz_q     <= dz_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against a plain-arithmetic HI/LO model.
// Optional div0_o checks follow MULDIV_DIV0_FLAG_EN.
module tb_muldiv_ctrl;

  localparam logic [5:0] T_MFHI  = 6'h10;
  localparam logic [5:0] T_MTHI  = 6'h11;
  localparam logic [5:0] T_MFLO  = 6'h12;
  localparam logic [5:0] T_MTLO  = 6'h13;
  localparam logic [5:0] T_MULT  = 6'h18;
  localparam logic [5:0] T_MULTU = 6'h19;
  localparam logic [5:0] T_DIV   = 6'h1A;
  localparam logic [5:0] T_DIVU  = 6'h1B;
  localparam logic [5:0] T_ADD   = 6'h20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_i, rt_i;
  logic        stall_o, busy_o, done_o;
  logic [31:0] mf_o, hi_o, lo_o;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div0_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_hi, exp_lo;
  int          exp_cyc;
  logic        exp_done;
  logic        exp_div0;

  muldiv_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .funct_i (funct_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .mf_o    (mf_o),
    .hi_o    (hi_o),
`ifdef MULDIV_DIV0_FLAG_EN
    .div0_o  (div0_o),
`endif
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op, straight from the MIPS definitions.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_cyc  = 0;
    exp_done = 1'b0;
    case (f)
      T_MTHI: exp_hi = a;
      T_MTLO: exp_lo = a;
      T_MULT: begin
        sp = sa * sb;
        exp_hi = sp[63:32]; exp_lo = sp[31:0];
        exp_cyc = 33; exp_done = 1'b1;
      end
      T_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        exp_hi = up[63:32]; exp_lo = up[31:0];
        exp_cyc = 33; exp_done = 1'b1;
      end
      T_DIV, T_DIVU: begin
        exp_done = 1'b1;
        if (b == 32'd0) begin
          exp_hi = a; exp_lo = 32'hFFFF_FFFF;
          exp_cyc = 1; exp_div0 = 1'b1;
        end else begin
          exp_cyc = 33; exp_div0 = 1'b0;
          if (f == T_DIV) begin
            sq = sa / sb; sr = sa % sb;
            exp_lo = sq[31:0]; exp_hi = sr[31:0];
          end else begin
            exp_lo = a / b; exp_hi = a % b;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    @(negedge clk);
    valid_i = 1'b1; funct_i = f; rs_i = a; rt_i = b;
    @(negedge clk);
    valid_i = 1'b0; funct_i = T_ADD;
    cyc = 0;
    while (busy_o && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    model(f, a, b);
    issue(f, a, b, cyc);
    chk("busy_cycles", 64'(cyc), 64'(exp_cyc));
    chk("done_pulse", 64'(done_o), 64'(exp_done));
    chk("hi", 64'(hi_o), 64'(exp_hi));
    chk("lo", 64'(lo_o), 64'(exp_lo));
`ifdef MULDIV_DIV0_FLAG_EN
    chk("div0", 64'(div0_o), 64'(exp_div0));
`endif
    @(negedge clk);
    chk("done_clear", 64'(done_o), 64'd0);
  endtask

  task automatic run_mf(input logic [5:0] f);
    @(negedge clk);
    valid_i = 1'b1; funct_i = f;
    #1 chk("mf_read", 64'(mf_o), (f == T_MFHI) ? 64'(exp_hi) : 64'(exp_lo));
    chk("mf_no_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0; funct_i = T_ADD;
  endtask

  initial begin
    logic [5:0]  fl [8];
    logic [31:0] a, b;
    int          n, pick;
    fl = '{T_MULT, T_MULTU, T_DIV, T_DIVU, T_MTHI, T_MTLO, T_MFHI, T_MFLO};

    rst_n = 1'b0; valid_i = 1'b0; funct_i = T_ADD; rs_i = '0; rt_i = '0;
    exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_n = 1'b1;

    run_op(T_MULT,  32'hFFFF_FFFF, 32'd2);
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(T_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(T_DIVU,  32'd100, 32'd0);
    run_op(T_DIVU,  32'd10, 32'd3);
    run_op(T_DIV,   32'h8000_0000, 32'd0);
    run_mf(T_MFHI);
    run_mf(T_MFLO);

    // mflo held while a mult runs; an unrelated funct mid-run must not stall.
    a = $urandom; b = $urandom;
    model(T_MULT, a, b);
    @(negedge clk);
    valid_i = 1'b1; funct_i = T_MULT; rs_i = a; rt_i = b;
    @(negedge clk);
    funct_i = T_MFLO;
    n = 0;
    while (busy_o && n < 100) begin
      if (n == 5) begin
        funct_i = T_ADD;
        #1 chk("stall_add", 64'(stall_o), 64'd0);
        funct_i = T_MFLO;
      end
      #1 chk("stall_mf", 64'(stall_o), 64'd1);
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 64'(n), 64'd33);
    #1 chk("stall_release", 64'(stall_o), 64'd0);
    chk("mf_after_stall", 64'(mf_o), 64'(exp_lo));
    @(negedge clk);
    valid_i = 1'b0; funct_i = T_ADD;

    // Asynchronous reset in the middle of a mult.
    run_op(T_MTHI, 32'h55, 32'd0);
    run_op(T_MTLO, 32'hAA, 32'd0);
    @(negedge clk);
    valid_i = 1'b1; funct_i = T_MULT; rs_i = 32'd12345; rt_i = 32'd678;
    @(negedge clk);
    valid_i = 1'b0; funct_i = T_ADD;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_hi", 64'(hi_o), 64'd0);
    chk("arst_lo", 64'(lo_o), 64'd0);
    exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(T_MTHI, 32'h1234, 32'd0);

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = -$urandom_range(0, 1000);
        default: ;
      endcase
      if (fl[pick] == T_MFHI || fl[pick] == T_MFLO) run_mf(fl[pick]);
      else run_op(fl[pick], a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
